// File: rtl/period_calc_arbiter.sv
// period_calc_arbiter: round-robin shared sequential divider computing DIVIDEND/(rate*10); optional per-requester result cache under PERIOD_CACHE_EN
module period_calc_arbiter #(
  parameter int unsigned DIVIDEND = 1967213,
  parameter int unsigned OUT_W = 16
) (
  input  logic             core_CLK,
  input  logic             core_nReset,
  input  logic             req_crank,
  input  logic [7:0]       rate_crank,
  input  logic             req_wheel,
  input  logic [7:0]       rate_wheel,
  output logic [OUT_W-1:0] period,
  output logic             done_crank,
  output logic             done_wheel,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  state_t state;
  logic owner;
  logic last_wheel;
  logic [7:0] rate_r;
  logic [11:0] divisor;
  logic [11:0] rem;
  logic [20:0] quo;
  logic [4:0] cnt;
  logic grant_wheel;
  logic [12:0] trial;
  logic fits;
  logic [11:0] rem_nxt;
  logic [20:0] quo_nxt;
  logic [OUT_W+20:0] quo_ext;
  logic [OUT_W-1:0] sat;
  logic hit;
  logic [OUT_W-1:0] hit_per;
  // Arbitration choice and one restoring-divide step, saturated to the output width
  always_comb begin
    grant_wheel = req_wheel & (~req_crank | ~last_wheel);
    trial = {rem, quo[20]};
    fits = trial >= {1'b0, divisor};
    rem_nxt = fits ? 12'(trial - {1'b0, divisor}) : trial[11:0];
    quo_nxt = {quo[19:0], fits};
    quo_ext = {{OUT_W{1'b0}}, quo_nxt};
    sat = |(quo_ext >> OUT_W) ? '1 : quo_ext[OUT_W-1:0];
  end
`ifdef PERIOD_CACHE_EN
  logic [1:0] c_valid;
  logic [1:0][7:0] c_rate;
  logic [1:0][OUT_W-1:0] c_per;
  assign hit = c_valid[owner] && c_rate[owner] == rate_r;
  assign hit_per = c_per[owner];
  // Remember the last fully computed rate and result of each requester
  always_ff @(posedge core_CLK)
    if (!core_nReset)
      c_valid <= '0;
    else if (state == DIV && cnt == 5'd20) begin
      c_valid[owner] <= 1'b1;
      c_rate[owner] <= rate_r;
      c_per[owner] <= sat;
    end
`else
  assign hit = 1'b0;
  assign hit_per = '0;
`endif
  // Control FSM with registered strobes, busy and result
  always_ff @(posedge core_CLK)
    if (!core_nReset) begin
      state <= IDLE;
      period <= '0;
      done_crank <= 1'b0;
      done_wheel <= 1'b0;
      busy <= 1'b0;
      last_wheel <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (req_crank | req_wheel) begin
            state <= LOAD;
            busy <= 1'b1;
            owner <= grant_wheel;
            rate_r <= grant_wheel ? rate_wheel : rate_crank;
          end
        LOAD: begin
          divisor <= 12'(rate_r) * 12'd10;
          rem <= '0;
          quo <= 21'(DIVIDEND);
          cnt <= '0;
          if (rate_r == 8'd0 || hit) begin
            state <= DONE;
            busy <= 1'b0;
            period <= rate_r == 8'd0 ? '1 : hit_per;
            done_crank <= ~owner;
            done_wheel <= owner;
          end else
            state <= DIV;
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd20) begin
            state <= DONE;
            busy <= 1'b0;
            period <= sat;
            done_crank <= ~owner;
            done_wheel <= owner;
          end
        end
        DONE: begin
          done_crank <= 1'b0;
          done_wheel <= 1'b0;
          last_wheel <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_period_calc_arbiter.sv
// tb_period_calc_arbiter: randomized scoreboard bench for period_calc_arbiter (honours PERIOD_CACHE_EN)
module tb_period_calc_arbiter;
  localparam int unsigned DIVIDEND = 1967213;
  localparam int OUT_W = 16;
  logic core_CLK = 1'b0;
  logic core_nReset = 1'b0;
  logic req_crank = 1'b0;
  logic req_wheel = 1'b0;
  logic [7:0] rate_crank = '0;
  logic [7:0] rate_wheel = '0;
  logic [OUT_W-1:0] period;
  logic done_crank, done_wheel, busy;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {logic w; logic [OUT_W-1:0] per; int g; int d;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic exp_busy;
  logic last_w = 1'b1;
`ifdef PERIOD_CACHE_EN
  logic [1:0] c_valid = '0;
  int c_rate[2];
  logic [OUT_W-1:0] c_per[2];
`endif

  period_calc_arbiter #(.DIVIDEND(DIVIDEND), .OUT_W(OUT_W)) dut (
    .core_CLK(core_CLK), .core_nReset(core_nReset),
    .req_crank(req_crank), .rate_crank(rate_crank),
    .req_wheel(req_wheel), .rate_wheel(rate_wheel),
    .period(period), .done_crank(done_crank), .done_wheel(done_wheel), .busy(busy)
  );

  always #5 core_CLK = ~core_CLK;
  always @(posedge core_CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_period(input int rate);
    longint qv;
    if (rate == 0) return '1;
    qv = longint'(DIVIDEND) / longint'(rate * 10);
    return qv > ((longint'(1) << OUT_W) - 1) ? '1 : OUT_W'(qv);
  endfunction

  // Predict one transaction granted at edge g; returns the edge at which its strobe appears
  function automatic int issue(input logic w, input int rate, input int g);
    exp_t x;
    int lat;
    x.w = w;
    x.per = ref_period(rate);
    lat = rate == 0 ? 2 : 23;
`ifdef PERIOD_CACHE_EN
    if (rate != 0 && c_valid[w] && c_rate[w] == rate) begin
      lat = 2;
      x.per = c_per[w];
    end else if (rate != 0) begin
      c_valid[w] = 1'b1;
      c_rate[w] = rate;
      c_per[w] = x.per;
    end
`endif
    x.g = g;
    x.d = g + lat - 1;
    sb.push_back(x);
    return x.d;
  endfunction

  // Monitor: sample just after each edge, compare against the scoreboard
  initial forever begin
    @(posedge core_CLK);
    #1;
    while (sb.size() > 0 && sb[0].d < cyc) begin
      chk("missing_done", cyc, sb[0].d);
      void'(sb.pop_front());
    end
    exp_busy = 1'b0;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].g <= cyc && cyc < sb[i].d) exp_busy = 1'b1;
    chk("busy", busy, exp_busy);
    chk("done_exclusive", done_crank & done_wheel, 0);
    if (done_crank | done_wheel) begin
      if (sb.size() == 0)
        chk("unexpected_done", {done_wheel, done_crank}, 0);
      else begin
        e = sb.pop_front();
        chk("owner_wheel", done_wheel, e.w);
        chk("period", period, e.per);
        chk("done_cycle", cyc, e.d);
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge core_CLK);
    core_nReset = 1'b0;
    req_crank = 1'b0;
    req_wheel = 1'b0;
    sb.delete();
    last_w = 1'b1;
`ifdef PERIOD_CACHE_EN
    c_valid = '0;
`endif
    repeat (n) @(negedge core_CLK);
    chk("rst_period", period, 0);
    chk("rst_done", {done_wheel, done_crank}, 0);
    chk("rst_busy", busy, 0);
    core_nReset = 1'b1;
  endtask

  task automatic run(input bit ce, input int rc, input bit we, input int rw, input bit drop);
    int g1, g2, d1;
    logic fw;
    @(negedge core_CLK);
    req_crank = ce;
    rate_crank = 8'(rc);
    req_wheel = we;
    rate_wheel = 8'(rw);
    g1 = cyc + 1;
    g2 = -1;
    if (ce && we) begin
      fw = ~last_w;
      d1 = issue(fw, fw ? rw : rc, g1);
      g2 = d1 + 2;
      void'(issue(~fw, fw ? rc : rw, g2));
      last_w = ~fw;
    end else begin
      fw = we;
      void'(issue(we, we ? rw : rc, g1));
      last_w = we;
    end
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(negedge core_CLK);
      if (done_crank) req_crank = 1'b0;
      if (done_wheel) req_wheel = 1'b0;
      if (cyc >= g1) begin
        if (fw) rate_wheel = 8'($urandom); else rate_crank = 8'($urandom);
        if (drop) begin
          if (fw) req_wheel = 1'b0; else req_crank = 1'b0;
        end
      end
      if (g2 >= 0 && cyc >= g2) begin
        if (fw) rate_crank = 8'($urandom); else rate_wheel = 8'($urandom);
      end
    end
    if (sb.size() > 0) begin
      chk("scenario_timeout", sb.size(), 0);
      sb.delete();
    end
    req_crank = 1'b0;
    req_wheel = 1'b0;
  endtask

  function automatic int pick_rate();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 60;
      3: return 100;
      4: return 255;
      default: return int'($urandom_range(2, 254));
    endcase
  endfunction

  initial begin
    int mode;
    do_reset(3);
    run(1, 60, 1, 100, 0);
    run(1, 60, 0, 0, 0);
    run(0, 0, 1, 0, 0);
    run(0, 0, 1, 1, 0);
    run(1, 60, 0, 0, 0);
    run(1, 61, 0, 0, 0);
    run(1, 255, 0, 0, 1);
    @(negedge core_CLK);
    req_crank = 1'b1;
    rate_crank = 8'd60;
    void'(issue(1'b0, 60, cyc + 1));
    repeat (10) @(negedge core_CLK);
    do_reset(3);
    repeat (30) @(negedge core_CLK);
    run(1, 60, 0, 0, 0);
    do_reset(2);
    run(1, 100, 1, 60, 0);
    for (int k = 0; k < 40; k++) begin
      mode = int'($urandom_range(0, 2));
      run(mode != 1, pick_rate(), mode != 0, pick_rate(), $urandom_range(0, 3) == 0);
    end
    repeat (5) @(negedge core_CLK);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog at cycle %0d: run did not complete", cyc);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
